// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM read/write port pair between instruction fetch and debug accesses.
// Optional perf counters are enabled with the MEM_ARB_PERF_CNT_EN define.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-3:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-3:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-3:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-3:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_conflicts,
    output logic [31:0]           perf_dbg_stall
`endif
);

    localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WaitMax = WW'(MAX_WAIT);

    logic                  d_busy_q, d_busy_d;
    logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                  d_elig, d_win, f_win, wait_inc;
    logic [RD_LATENCY-1:0] tag_f_q, tag_d_q, tag_w_q;
    logic [ADDR_WIDTH-3:0] rd_addr_q, wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    assign d_elig   = d_req && !d_busy_q;
    assign d_win    = d_elig && (!f_req || (wait_cnt_q == WaitMax));
    assign f_win    = f_req && !d_win;
    // Grants are forced low while in reset so every output reads 0.
    assign f_gnt    = rst_n && f_win;
    assign d_gnt    = rst_n && d_win;
    assign wait_inc = d_elig && !d_gnt;

    assign ram_rd_en = f_gnt || (d_gnt && !d_wr);
    assign ram_wr_en = d_gnt && d_wr;

    always_comb begin
        ram_rd_addr = rd_addr_q;
        ram_wr_addr = wr_addr_q;
        ram_wr_data = wr_data_q;
        if (f_gnt) begin
            ram_rd_addr = f_addr;
        end else if (ram_rd_en) begin
            ram_rd_addr = d_addr;
        end
        if (ram_wr_en) begin
            ram_wr_addr = d_addr;
            ram_wr_data = d_wdata;
        end
    end

    assign f_rvalid = tag_f_q[RD_LATENCY-1];
    assign f_rdata  = tag_f_q[RD_LATENCY-1] ? ram_rd_data : '0;
    assign d_rvalid = tag_d_q[RD_LATENCY-1] || tag_w_q[RD_LATENCY-1];
    assign d_rdata  = tag_d_q[RD_LATENCY-1] ? ram_rd_data : '0;

    always_comb begin
        d_busy_d   = d_busy_q;
        wait_cnt_d = wait_cnt_q;
        if (d_gnt) begin
            d_busy_d = 1'b1;
        end else if (d_rvalid) begin
            d_busy_d = 1'b0;
        end
        if (!d_req || d_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_inc && (wait_cnt_q != WaitMax)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_busy_q   <= 1'b0;
            wait_cnt_q <= '0;
            tag_f_q    <= '0;
            tag_d_q    <= '0;
            tag_w_q    <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            d_busy_q   <= d_busy_d;
            wait_cnt_q <= wait_cnt_d;
            // Tags travel alongside the RAM read so data returns to its owner in grant order.
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_f_q[i] <= tag_f_q[i-1];
                tag_d_q[i] <= tag_d_q[i-1];
                tag_w_q[i] <= tag_w_q[i-1];
            end
            tag_f_q[0] <= f_gnt;
            tag_d_q[0] <= d_gnt && !d_wr;
            tag_w_q[0] <= d_gnt && d_wr;
            if (ram_rd_en) begin
                rd_addr_q <= ram_rd_addr;
            end
            if (ram_wr_en) begin
                wr_addr_q <= ram_wr_addr;
                wr_data_q <= ram_wr_data;
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_conflicts_q, perf_dbg_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflicts_q <= '0;
            perf_dbg_stall_q <= '0;
        end else begin
            if (f_req && d_req && !d_busy_q) begin
                perf_conflicts_q <= perf_conflicts_q + 32'd1;
            end
            if (wait_inc) begin
                perf_dbg_stall_q <= perf_dbg_stall_q + 32'd1;
            end
        end
    end

    assign perf_conflicts = perf_conflicts_q;
    assign perf_dbg_stall = perf_dbg_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MAX_WAIT 4 and 0) share stimulus, each with its own RAM
// and a cycle-level behavioural model; directed scenarios add hand-computed literal checks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [29:0] f_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [29:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic        f_gnt[2], f_rvalid[2], d_gnt[2], d_rvalid[2], ram_rd_en[2], ram_wr_en[2];
    logic [31:0] f_rdata[2], d_rdata[2], ram_rd_data[2], ram_wr_data[2];
    logic [29:0] ram_rd_addr[2], ram_wr_addr[2];
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_conf[2], perf_stall[2];
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .RD_LATENCY(1),
            .MAX_WAIT  ((k == 0) ? 4 : 0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .f_req      (f_req),
            .f_addr     (f_addr),
            .f_gnt      (f_gnt[k]),
            .f_rvalid   (f_rvalid[k]),
            .f_rdata    (f_rdata[k]),
            .d_req      (d_req),
            .d_wr       (d_wr),
            .d_addr     (d_addr),
            .d_wdata    (d_wdata),
            .d_gnt      (d_gnt[k]),
            .d_rvalid   (d_rvalid[k]),
            .d_rdata    (d_rdata[k]),
            .ram_rd_en  (ram_rd_en[k]),
            .ram_rd_addr(ram_rd_addr[k]),
            .ram_rd_data(ram_rd_data[k]),
            .ram_wr_en  (ram_wr_en[k]),
            .ram_wr_addr(ram_wr_addr[k]),
            .ram_wr_data(ram_wr_data[k])
`ifdef MEM_ARB_PERF_CNT_EN
            ,
            .perf_conflicts(perf_conf[k]),
            .perf_dbg_stall(perf_stall[k])
`endif
        );
    end

    // RAM stand-ins with one cycle read latency; model memory starts with identical contents.
    logic [31:0] ram[2][256];
    logic [31:0] mmem[2][256];
    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) begin
                ram[k][i]  = {24'hC0FFEE, i[7:0]};
                mmem[k][i] = {24'hC0FFEE, i[7:0]};
            end
            ram_rd_data[k] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_rd_en[k]) ram_rd_data[k] <= ram[k][ram_rd_addr[k][7:0]];
            if (ram_wr_en[k]) ram[k][ram_wr_addr[k][7:0]] = ram_wr_data[k];
        end
    end

    task automatic chk(input int k, input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: counts consecutive denied cycles, tracks one outstanding debug op and the
    // response each owner is due next cycle.
    int          waited[2] = '{0, 0};
    bit          dbg_out[2] = '{0, 0};
    bit          ef[2] = '{0, 0};
    bit          ed[2] = '{0, 0};
    logic [31:0] efd[2], edd[2];
    bit          m_elig, m_dw, m_fw;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk(k, "rst_f_gnt", f_gnt[k], 0);
                chk(k, "rst_d_gnt", d_gnt[k], 0);
                chk(k, "rst_f_rvalid", f_rvalid[k], 0);
                chk(k, "rst_d_rvalid", d_rvalid[k], 0);
                chk(k, "rst_rd_en", ram_rd_en[k], 0);
                chk(k, "rst_wr_en", ram_wr_en[k], 0);
                chk(k, "rst_f_rdata", f_rdata[k], 0);
                chk(k, "rst_d_rdata", d_rdata[k], 0);
                chk(k, "rst_rd_addr", ram_rd_addr[k], 0);
                chk(k, "rst_wr_addr", ram_wr_addr[k], 0);
                chk(k, "rst_wr_data", ram_wr_data[k], 0);
                waited[k]  = 0;
                dbg_out[k] = 0;
                ef[k]      = 0;
                ed[k]      = 0;
            end else begin
                m_elig = d_req && !dbg_out[k];
                m_dw   = m_elig && (!f_req || waited[k] >= ((k == 0) ? 4 : 0));
                m_fw   = f_req && !m_dw;
                chk(k, "f_gnt", f_gnt[k], m_fw);
                chk(k, "d_gnt", d_gnt[k], m_dw);
                chk(k, "ram_rd_en", ram_rd_en[k], m_fw || (m_dw && !d_wr));
                chk(k, "ram_wr_en", ram_wr_en[k], m_dw && d_wr);
                if (m_fw) chk(k, "ram_rd_addr_f", ram_rd_addr[k], f_addr);
                if (m_dw && !d_wr) chk(k, "ram_rd_addr_d", ram_rd_addr[k], d_addr);
                if (m_dw && d_wr) begin
                    chk(k, "ram_wr_addr", ram_wr_addr[k], d_addr);
                    chk(k, "ram_wr_data", ram_wr_data[k], d_wdata);
                end
                chk(k, "f_rvalid", f_rvalid[k], ef[k]);
                chk(k, "f_rdata", f_rdata[k], ef[k] ? efd[k] : 32'h0);
                chk(k, "d_rvalid", d_rvalid[k], ed[k]);
                chk(k, "d_rdata", d_rdata[k], ed[k] ? edd[k] : 32'h0);
                if (ed[k]) dbg_out[k] = 0;
                if (m_dw) dbg_out[k] = 1;
                if (!d_req || m_dw) waited[k] = 0;
                else if (m_elig) waited[k]++;
                ef[k]  = m_fw;
                efd[k] = mmem[k][f_addr[7:0]];
                ed[k]  = m_dw;
                edd[k] = d_wr ? 32'h0 : mmem[k][d_addr[7:0]];
                if (m_dw && d_wr) mmem[k][d_addr[7:0]] = d_wdata;
            end
        end
    end

    task automatic cyc(input logic fr, input logic [29:0] fa, input logic dr, input logic dw,
                       input logic [29:0] da, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        f_req = fr; f_addr = fa; d_req = dr; d_wr = dw; d_addr = da; d_wdata = dwd;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a pending fetch request: grant must stay low.
        f_req = 1'b1;
        f_addr = 30'h7;
        repeat (2) @(negedge clk);
        chk(0, "lit_rst_f_gnt", f_gnt[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        f_req = 1'b0;

        // Fetch stream, back-to-back.
        cyc(1, 30'h10, 0, 0, 0, 0);
        chk(0, "lit_s1_gnt0", f_gnt[0], 1);
        cyc(1, 30'h11, 0, 0, 0, 0);
        chk(0, "lit_s1_gnt1", f_gnt[0], 1);
        chk(0, "lit_s1_rdata0", f_rdata[0], 32'hC0FFEE10);
        cyc(1, 30'h12, 0, 0, 0, 0);
        chk(0, "lit_s1_rdata1", f_rdata[0], 32'hC0FFEE11);
        cyc(0, 30'h12, 0, 0, 0, 0);
        chk(0, "lit_s1_rdata2", f_rdata[0], 32'hC0FFEE12);
        chk(0, "lit_s1_idle_rd_en", ram_rd_en[0], 0);

        // Debug write, ack, then read back.
        cyc(0, 0, 1, 1, 30'h20, 32'hDEADBEEF);
        chk(0, "lit_s2_wr_gnt", d_gnt[0], 1);
        chk(0, "lit_s2_wr_en", ram_wr_en[0], 1);
        cyc(0, 0, 0, 0, 30'h20, 0);
        chk(0, "lit_s2_wr_pulse", ram_wr_en[0], 0);
        chk(0, "lit_s2_ack", d_rvalid[0], 1);
        chk(0, "lit_s2_ack_data", d_rdata[0], 0);
        cyc(0, 0, 1, 0, 30'h20, 0);
        chk(0, "lit_s2_rd_gnt", d_gnt[0], 1);
        cyc(0, 0, 0, 0, 30'h20, 0);
        chk(0, "lit_s2_rdata", d_rdata[0], 32'hDEADBEEF);

        // Starvation bound: MAX_WAIT=4 grants debug on the 5th contended cycle.
        for (int i = 0; i < 6; i++) begin
            cyc(1, (i <= 4) ? 30'(32'h30 + i) : 30'h34, (i < 5), 0, 30'h11, 0);
            chk(0, "lit_s3_d_gnt", d_gnt[0], (i == 4));
            chk(0, "lit_s3_f_gnt", f_gnt[0], (i != 4));
        end
        chk(0, "lit_s3_rvalid", d_rvalid[0], 1);
        chk(0, "lit_s3_rdata", d_rdata[0], 32'hC0FFEE11);
`ifdef MEM_ARB_PERF_CNT_EN
        chk(0, "lit_s6_conflicts", perf_conf[0], 5);
        chk(0, "lit_s6_stall", perf_stall[0], 4);
`endif

        // MAX_WAIT=0: debug wins at once, held request blocked until the response.
        cyc(1, 30'h40, 1, 0, 30'h12, 0);
        chk(1, "lit_s4_d_gnt0", d_gnt[1], 1);
        chk(1, "lit_s4_f_gnt0", f_gnt[1], 0);
        cyc(1, 30'h40, 1, 0, 30'h12, 0);
        chk(1, "lit_s4_busy_d_gnt", d_gnt[1], 0);
        chk(1, "lit_s4_busy_f_gnt", f_gnt[1], 1);
        chk(1, "lit_s4_rdata", d_rdata[1], 32'hC0FFEE12);
        cyc(1, 30'h40, 1, 0, 30'h12, 0);
        chk(1, "lit_s4_d_gnt2", d_gnt[1], 1);
        cyc(1, 30'h40, 0, 0, 30'h12, 0);
        chk(1, "lit_s4_f_gnt3", f_gnt[1], 1);

        // Reset while a debug read is in flight.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 30'h10, 0);
        chk(0, "lit_s5_d_gnt", d_gnt[0], 1);
        @(posedge clk); #1;
        rst_n = 1'b0; f_req = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk(0, "lit_s5_rst_rvalid", d_rvalid[0], 0);
        chk(0, "lit_s5_rst_f_gnt", f_gnt[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1; f_req = 1'b0;
        @(negedge clk);
        chk(0, "lit_s5_post_d_rvalid", d_rvalid[0], 0);
        chk(0, "lit_s5_post_f_rvalid", f_rvalid[0], 0);
`ifdef MEM_ARB_PERF_CNT_EN
        chk(0, "lit_s5_perf_clr", perf_conf[0], 0);
`endif
        cyc(1, 30'h05, 0, 0, 0, 0);
        chk(0, "lit_s5_f_gnt", f_gnt[0], 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk(0, "lit_s5_f_rdata", f_rdata[0], 32'hC0FFEE05);
        cyc(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
